// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
//
// Front-panel sequencer for the time-of-day counter. It turns two debounced
// pushbuttons (MODE, INC) into the following signals:
//   - the counter field select (ORDER),
//   - one-cycle INCREMENT strobes,
//   - a run enable that freezes timekeeping while a field is edited,
//   - a blink enable for the digits of the field being edited.
//
// Optional build macro:
//   AUTO_REPEAT_EN  When defined, holding INC auto-repeats the increment.
//                   The first repeat comes HOLD_CYCLES after the press, then
//                   one every REPEAT_CYCLES. When undefined, each press gives
//                   exactly one strobe and no hold counter is built.
//
// Ports:
//   CLK        in   system clock (50 MHz)
//   RST        in   synchronous reset, active-low, sampled on the CLK rising edge
//   MODE_BTN   in   debounced, CLK-synchronous mode button, active-high
//   INC_BTN    in   debounced, CLK-synchronous increment button, active-high
//   ORDER      out  [1:0] field select: 00 sec, 01 min, 10 hr, 11 none
//   INCREMENT  out  one-cycle strobe: increment the field selected by ORDER
//   RUN_EN     out  1 = time counter advances, 0 = frozen for editing
//   BLINK      out  display enable for the selected field (1 = shown)
//   EDITING    out  1 in any edit state
// -----------------------------------------------------------------------------
module clock_set_controller #(
  parameter int unsigned HOLD_CYCLES    = 32'd25000000,
  parameter int unsigned REPEAT_CYCLES  = 32'd5000000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd500000000,
  parameter int unsigned BLINK_CYCLES   = 32'd12500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       MODE_BTN,
  input  logic       INC_BTN,
  output logic [1:0] ORDER,
  output logic       INCREMENT,
  output logic       RUN_EN,
  output logic       BLINK,
  output logic       EDITING
);

  // Reject parameter values that would make the counters meaningless.
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (BLINK_CYCLES < 1) begin : g_chk_blink
    $error("BLINK_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_chk_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] BLINK_LIM   = 32'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_HR,
    ST_SET_MIN,
    ST_SET_SEC
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  order_q, order_d;
  logic        increment_q, increment_d;
  logic        run_en_q, run_en_d;
  logic        blink_q, blink_d;
  logic        editing_q, editing_d;
  logic        mode_hist_q, mode_hist_d;
  logic        inc_hist_q, inc_hist_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;

  logic        mode_press;
  logic        inc_press;
  logic        in_edit;
  logic        timeout;
  logic        state_chg;
  logic        take_inc;
  logic        repeat_fire;
  logic        strobe;

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] HOLD_LIM   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REPEAT_LIM = 32'(REPEAT_CYCLES - 1);

  logic        holding_q, holding_d;
  logic        repeating_q, repeating_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    mode_press = MODE_BTN & ~mode_hist_q;
    inc_press  = INC_BTN & ~inc_hist_q;
    in_edit    = (state_q != ST_RUN);
    timeout    = in_edit && (idle_q >= TIMEOUT_LIM);

    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        ST_RUN:     state_d = ST_SET_HR;
        ST_SET_HR:  state_d = ST_SET_MIN;
        ST_SET_MIN: state_d = ST_SET_SEC;
        default:    state_d = ST_RUN;
      endcase
    end else if (timeout) begin
      state_d = ST_RUN;
    end
    state_chg = (state_d != state_q);

    // MODE and timeout both take priority over INC. This guarantees that a
    // strobe never lands on the same edge as an ORDER change.
    take_inc    = in_edit & ~mode_press & ~timeout;
    repeat_fire = 1'b0;

`ifdef AUTO_REPEAT_EN
    holding_d   = holding_q;
    repeating_d = repeating_q;
    hold_cnt_d  = hold_cnt_q;
    if (!(take_inc && INC_BTN)) begin
      holding_d   = 1'b0;
      repeating_d = 1'b0;
      hold_cnt_d  = '0;
    end else if (inc_press) begin
      holding_d   = 1'b1;
      repeating_d = 1'b0;
      hold_cnt_d  = '0;
    end else if (holding_q) begin
      // The first limit counts out the initial hold delay. After that, the
      // same counter is reused for the repeat period.
      if (hold_cnt_q >= (repeating_q ? REPEAT_LIM : HOLD_LIM)) begin
        repeat_fire = 1'b1;
        repeating_d = 1'b1;
        hold_cnt_d  = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 32'd1;
      end
    end
`endif

    strobe = take_inc & (inc_press | repeat_fire);

    if ((state_d == ST_RUN) || state_chg || mode_press || inc_press || repeat_fire) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 32'd1;
    end

    if ((state_d == ST_RUN) || state_chg || strobe) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q >= BLINK_LIM) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 32'd1;
      blink_d     = blink_q;
    end

    case (state_d)
      ST_RUN:     order_d = 2'b11;
      ST_SET_HR:  order_d = 2'b10;
      ST_SET_MIN: order_d = 2'b01;
      default:    order_d = 2'b00;
    endcase
    run_en_d    = (state_d == ST_RUN);
    editing_d   = (state_d != ST_RUN);
    increment_d = strobe;
    mode_hist_d = MODE_BTN;
    inc_hist_d  = INC_BTN;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_RUN;
      order_q     <= 2'b11;
      increment_q <= 1'b0;
      run_en_q    <= 1'b1;
      blink_q     <= 1'b1;
      editing_q   <= 1'b0;
      // History registers reset high, so a button held through reset does
      // not register as a press.
      mode_hist_q <= 1'b1;
      inc_hist_q  <= 1'b1;
      idle_q      <= '0;
      blink_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
      holding_q   <= 1'b0;
      repeating_q <= 1'b0;
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      order_q     <= order_d;
      increment_q <= increment_d;
      run_en_q    <= run_en_d;
      blink_q     <= blink_d;
      editing_q   <= editing_d;
      mode_hist_q <= mode_hist_d;
      inc_hist_q  <= inc_hist_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
`ifdef AUTO_REPEAT_EN
      holding_q   <= holding_d;
      repeating_q <= repeating_d;
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign ORDER     = order_q;
  assign INCREMENT = increment_q;
  assign RUN_EN    = run_en_q;
  assign BLINK     = blink_q;
  assign EDITING   = editing_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_set_controller
//
// Bench for clock_set_controller, using small parameter values:
//   HOLD=8, REPEAT=4, TIMEOUT=32, BLINK=4.
//
// The reference model works from event times rather than counters:
//   - the edge number of the last press / activity / blink restart,
//   - a field index 0..3.
// Directed sequences add literal expectations on top of the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_set_controller;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int TMO  = 32;
  localparam int BLK  = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       mode = 1'b0;
  logic       inc  = 1'b0;
  logic [1:0] order;
  logic       increment;
  logic       run_en;
  logic       blink;
  logic       editing;

  int n_vec     = 0;
  int n_miss    = 0;
  int n_strobes = 0;

  clock_set_controller #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .TIMEOUT_CYCLES(TMO),
    .BLINK_CYCLES  (BLK)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .MODE_BTN (mode),
    .INC_BTN  (inc),
    .ORDER    (order),
    .INCREMENT(increment),
    .RUN_EN   (run_en),
    .BLINK    (blink),
    .EDITING  (editing)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // field: 0 = running, 1 = hours, 2 = minutes, 3 = seconds
  logic [1:0] order_of_field [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
  int t        = 0;
  bit m_valid  = 1'b0;
  int m_field  = 0;
  bit m_strobe = 1'b0;
  bit m_mh     = 1'b1;
  bit m_ih     = 1'b1;
  bit m_held   = 1'b0;
  int m_press_t = 0;
  int m_act_t   = 0;
  int m_blink_t = 0;

  always @(posedge clk) begin : model
    bit mp, ip, edit, to, take, rep;
    int nf, d;
    t++;
    if (!rst) begin
      m_valid  = 1'b1;
      m_field  = 0;
      m_strobe = 1'b0;
      m_mh     = 1'b1;
      m_ih     = 1'b1;
      m_held   = 1'b0;
    end else if (m_valid) begin
      mp   = mode && !m_mh;
      ip   = inc && !m_ih;
      edit = (m_field != 0);
      to   = edit && ((t - m_act_t) >= TMO);
      nf   = m_field;
      if (mp) nf = (m_field + 1) % 4;
      else if (to) nf = 0;
      take = edit && !mp && !to;
      rep  = 1'b0;
`ifdef AUTO_REPEAT_EN
      if (take && inc && m_held) begin
        d = t - m_press_t;
        if (d >= HOLD && ((d - HOLD) % REP) == 0) rep = 1'b1;
      end
`else
      d = 0;
`endif
      if (!(take && inc)) m_held = 1'b0;
      if (take && ip) begin
        m_held    = 1'b1;
        m_press_t = t;
      end
      m_strobe = take && (ip || rep);
      if (mp || ip || rep || (nf != m_field)) m_act_t = t;
      if ((nf != m_field) || m_strobe) m_blink_t = t;
      m_field = nf;
      m_mh    = mode;
      m_ih    = inc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [5:0] act, exp;
    bit         bl;
    if (m_valid) begin
      bl  = (m_field == 0) ? 1'b1 : ((((t - m_blink_t) / BLK) % 2) == 0);
      exp = {order_of_field[m_field], m_strobe, (m_field == 0), bl, (m_field != 0)};
      act = {order, increment, run_en, blink, editing};
      n_vec++;
      if (act !== exp) begin
        n_miss++;
        $display("FAIL cycle edge=%0d {ORDER,INC,RUN_EN,BLINK,EDIT}: got %b required %b",
                 t, act, exp);
      end
      if (increment === 1'b1) n_strobes++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_mode();
    mode = 1'b1;
    @(negedge clk);
    mode = 1'b0;
  endtask

  initial begin : stim
    int s0;
    logic [31:0] mask, exp_mask;

    // Reset state
    rst = 1'b0;
    tick(3);
    check("rst_order",   32'(order),     32'h3);
    check("rst_inc",     32'(increment), 32'h0);
    check("rst_run_en",  32'(run_en),    32'h1);
    check("rst_blink",   32'(blink),     32'h1);
    check("rst_editing", 32'(editing),   32'h0);
    rst = 1'b1;
    tick(2);

    // 1: MODE walks through the fields and back to RUN
    pulse_mode();
    check("t1_order_hr", 32'(order), 32'h2);
    check("t1_run_hr",   32'(run_en), 32'h0);
    check("t1_edit_hr",  32'(editing), 32'h1);
    tick(2);
    pulse_mode();
    check("t1_order_min", 32'(order), 32'h1);
    tick(2);
    pulse_mode();
    check("t1_order_sec", 32'(order), 32'h0);
    check("t1_run_sec",   32'(run_en), 32'h0);
    tick(2);
    pulse_mode();
    check("t1_order_run", 32'(order), 32'h3);
    check("t1_run_run",   32'(run_en), 32'h1);
    check("t1_edit_run",  32'(editing), 32'h0);
    tick(2);

    // 2: INC press in SET_MIN gives one strobe a cycle later; INC in RUN is ignored
    pulse_mode(); tick(1);
    pulse_mode(); tick(1);
    inc = 1'b1;
    @(negedge clk);
    check("t2_strobe",       32'(increment), 32'h1);
    check("t2_order_strobe", 32'(order),     32'h1);
    inc = 1'b0;
    @(negedge clk);
    check("t2_strobe_end", 32'(increment), 32'h0);
    check("t2_order_after", 32'(order),    32'h1);
    tick(1);
    pulse_mode(); tick(1);
    pulse_mode(); tick(1);
    s0  = n_strobes;
    inc = 1'b1;
    tick(2);
    inc = 1'b0;
    tick(2);
    check("t2_run_no_strobe", 32'(n_strobes - s0), 32'h0);
    check("t2_run_order",     32'(order),          32'h3);

    // 3: MODE and INC at the same edge in SET_HR; MODE wins
    pulse_mode(); tick(1);
    s0   = n_strobes;
    mode = 1'b1;
    inc  = 1'b1;
    @(negedge clk);
    check("t3_order_min", 32'(order),     32'h1);
    check("t3_no_inc",    32'(increment), 32'h0);
    mode = 1'b0;
    inc  = 1'b0;
    tick(2);
    check("t3_no_strobe", 32'(n_strobes - s0), 32'h0);

    // 4: SET_SEC idles to timeout; blink half-period is 4 cycles
    pulse_mode();
    check("t4_order_sec", 32'(order), 32'h0);
    check("t4_blink_e0",  32'(blink), 32'h1);
    tick(3);
    check("t4_blink_e3",  32'(blink), 32'h1);
    tick(1);
    check("t4_blink_e4",  32'(blink), 32'h0);
    tick(4);
    check("t4_blink_e8",  32'(blink), 32'h1);
    tick(23);
    check("t4_order_e31", 32'(order),  32'h0);
    check("t4_run_e31",   32'(run_en), 32'h0);
    tick(1);
    check("t4_order_e32", 32'(order),  32'h3);
    check("t4_run_e32",   32'(run_en), 32'h1);
    check("t4_blink_e32", 32'(blink),  32'h1);
    tick(3);

    // 5: INC held 20 cycles in SET_HR
    pulse_mode(); tick(1);
    mask = '0;
    inc  = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (increment === 1'b1) mask[k] = 1'b1;
      if (k == 20) inc = 1'b0;
    end
`ifdef AUTO_REPEAT_EN
    exp_mask = 32'h0002_2202;
`else
    exp_mask = 32'h0000_0002;
`endif
    check("t5_strobe_cycles", mask, exp_mask);
    check("t5_order_hr",      32'(order), 32'h2);

    // 6: reset mid-edit with INC held through release
    pulse_mode(); tick(1);
    inc = 1'b1;
    @(negedge clk);
    check("t6_press_strobe", 32'(increment), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_order", 32'(order),     32'h3);
    check("t6_rst_inc",   32'(increment), 32'h0);
    check("t6_rst_run",   32'(run_en),    32'h1);
    rst = 1'b1;
    s0  = n_strobes;
    tick(12);
    check("t6_no_strobe", 32'(n_strobes - s0), 32'h0);
    check("t6_order_run", 32'(order),          32'h3);
    inc = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
